// File: rtl/sp_sram_fifo_ctrl_pkg.sv
// Shared width helpers for the single-port SRAM FIFO controller.
// Address and occupancy widths are derived from the SRAM depth.
package sp_sram_fifo_ctrl_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // SRAM address width; a 1-entry address still needs one bit.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (clog2(depth) > 1) ? clog2(depth) : 1;
    endfunction

    // Occupancy counter width: SRAM entries + output stage + one read in flight.
    function automatic int unsigned count_w(input int unsigned depth);
        return clog2(depth + 2);
    endfunction

endpackage

// File: rtl/sp_sram_fifo_ctrl.sv
// FIFO controller driving a 1-cycle-latency single-port SRAM, with a registered
// output stage and an empty-queue bypass. Capacity is DEPTH+1 words.
module sp_sram_fifo_ctrl
    import sp_sram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 72,
    parameter int unsigned DEPTH = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        enq_valid,
    output logic                        enq_ready,
    input  logic [WIDTH-1:0]            enq_bits,
    output logic                        deq_valid,
    input  logic                        deq_ready,
    output logic [WIDTH-1:0]            deq_bits,
    output logic [count_w(DEPTH)-1:0]   count,
    output logic                        sram_en,
    output logic                        sram_wmode,
    output logic [addr_w(DEPTH)-1:0]    sram_addr,
    output logic [WIDTH-1:0]            sram_wdata,
    input  logic [WIDTH-1:0]            sram_rdata
);

    localparam int unsigned ADDR_W  = addr_w(DEPTH);
    localparam int unsigned COUNT_W = count_w(DEPTH);
    localparam int unsigned CNT_W   = ADDR_W + 1;

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]  sram_cnt_q, sram_cnt_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;

    logic rd_issue;
    logic bypass;
    logic enq_fire;
    logic deq_fire;
    logic wr_issue;

    // bypass and rd_issue use registered terms only, so deq_ready never reaches enq_ready.
    assign rd_issue  = (sram_cnt_q != '0) && !rd_inflight_q && !out_valid_q && !flush;
    assign bypass    = (sram_cnt_q == '0) && !rd_inflight_q && !out_valid_q;
    assign enq_ready = !flush && !rd_issue && (bypass || (sram_cnt_q < CNT_W'(DEPTH)));
    assign enq_fire  = enq_valid && enq_ready;
    assign wr_issue  = enq_fire && !bypass;
    assign deq_valid = out_valid_q && !flush;
    assign deq_fire  = deq_valid && deq_ready;
    assign deq_bits  = out_data_q;

    assign sram_en    = rd_issue || wr_issue;
    assign sram_wmode = wr_issue;
    assign sram_addr  = wr_issue ? wptr_q : rptr_q;
    assign sram_wdata = enq_bits;

    assign count = COUNT_W'(sram_cnt_q) + COUNT_W'(out_valid_q) + COUNT_W'(rd_inflight_q);

    always_comb begin
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        sram_cnt_d    = sram_cnt_q;
        rd_inflight_d = rd_inflight_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        if (flush) begin
            wptr_d        = '0;
            rptr_d        = '0;
            sram_cnt_d    = '0;
            rd_inflight_d = 1'b0;
            out_valid_d   = 1'b0;
        end else begin
            if (rd_inflight_q) begin
                out_data_d    = sram_rdata;
                out_valid_d   = 1'b1;
                rd_inflight_d = 1'b0;
            end
            if (rd_issue) begin
                rptr_d        = rptr_q + ADDR_W'(1);
                sram_cnt_d    = sram_cnt_q - CNT_W'(1);
                rd_inflight_d = 1'b1;
            end
            if (enq_fire && bypass) begin
                out_data_d  = enq_bits;
                out_valid_d = 1'b1;
            end
            if (wr_issue) begin
                wptr_d     = wptr_q + ADDR_W'(1);
                sram_cnt_d = sram_cnt_q + CNT_W'(1);
            end
            if (deq_fire) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            sram_cnt_q    <= '0;
            rd_inflight_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            sram_cnt_q    <= sram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

endmodule

// File: tb/tb_sp_sram_fifo_ctrl.sv
// Scoreboard bench for sp_sram_fifo_ctrl with a behavioural 1-cycle-latency SRAM.
// Stimulus pushes expected words; a negedge monitor pops and compares on each deq.
module tb_sp_sram_fifo_ctrl;

    localparam int unsigned WIDTH  = 72;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned ADDR_W = 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              flush;
    logic              enq_valid;
    logic              enq_ready;
    logic [WIDTH-1:0]  enq_bits;
    logic              deq_valid;
    logic              deq_ready;
    logic [WIDTH-1:0]  deq_bits;
    logic [1:0]        count;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [WIDTH-1:0]  sram_wdata;
    logic [WIDTH-1:0]  sram_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH-1:0]  exp_q[$];
    logic [ADDR_W-1:0] exp_waddr = '0;
    logic [ADDR_W-1:0] exp_raddr = '0;
    logic              last_en, last_wmode;
    logic [ADDR_W-1:0] last_addr;
    bit                stim_done;

    logic [WIDTH-1:0]  mem [DEPTH];

    always #5 clock = ~clock;

    sp_sram_fifo_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .enq_valid  (enq_valid),
        .enq_ready  (enq_ready),
        .enq_bits   (enq_bits),
        .deq_valid  (deq_valid),
        .deq_ready  (deq_ready),
        .deq_bits   (deq_bits),
        .count      (count),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Read data is garbage except in the cycle after a read.
    always @(posedge clock) begin
        if (sram_en && sram_wmode) mem[sram_addr] <= sram_wdata;
        sram_rdata <= (sram_en && !sram_wmode) ? mem[sram_addr] : {9{8'hEE}};
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset || flush) begin
            if (flush && !reset) begin
                check("flush_enq_ready", enq_ready, 0);
                check("flush_deq_valid", deq_valid, 0);
                check("flush_sram_en", sram_en, 0);
            end
            exp_q.delete();
            exp_waddr = '0;
            exp_raddr = '0;
        end else begin
            if (sram_en) begin
                if (sram_wmode) begin
                    check("write_addr", sram_addr, exp_waddr);
                    check("write_data", sram_wdata, enq_bits);
                    exp_waddr = exp_waddr + 1'b1;
                end else begin
                    check("read_addr", sram_addr, exp_raddr);
                    check("read_blocks_enq", enq_ready, 0);
                    exp_raddr = exp_raddr + 1'b1;
                end
            end
            if (deq_valid && deq_ready) begin
                if (exp_q.size() == 0) begin
                    check("deq_unexpected", deq_valid, 0);
                end else begin
                    check("deq_bits", deq_bits, exp_q.pop_front());
                end
            end
        end
    end

    task automatic enq(input logic [WIDTH-1:0] d);
        bit done;
        done = 0;
        enq_valid = 1'b1;
        enq_bits  = d;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clock);
            if (enq_ready) begin
                exp_q.push_back(d);
                last_en    = sram_en;
                last_wmode = sram_wmode;
                last_addr  = sram_addr;
                done       = 1;
            end
            @(posedge clock);
            #1;
        end
        enq_valid = 1'b0;
        if (!done) check("enq_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
        check("drain_left", exp_q.size(), 0);
        @(posedge clock);
        #1;
        check("drain_count", count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_bits = '0; deq_ready = 1'b0;
        @(negedge clock);
        check("rst_deq_valid", deq_valid, 0);
        check("rst_sram_en", sram_en, 0);
        check("rst_count", count, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_enq_ready", enq_ready, 1);
        @(posedge clock); #1;

        // 1: bypass
        deq_ready = 1'b1;
        enq(72'hA5);
        check("t1_no_sram", last_en, 0);
        @(negedge clock);
        check("t1_deq_valid", deq_valid, 1);
        @(posedge clock); #1;
        check("t1_count", count, 0);

        // 2: fill
        deq_ready = 1'b0;
        enq(72'h1);
        check("t2_w1_en", last_en, 0);
        enq(72'h2);
        check("t2_w2_en", last_en, 1);
        check("t2_w2_wmode", last_wmode, 1);
        check("t2_w2_addr", last_addr, 0);
        enq(72'h3);
        check("t2_w3_en", last_en, 1);
        check("t2_w3_wmode", last_wmode, 1);
        check("t2_w3_addr", last_addr, 1);
        enq_valid = 1'b1; enq_bits = 72'h4;
        @(negedge clock);
        check("t2_full_ready", enq_ready, 0);
        check("t2_full_count", count, 3);
        @(posedge clock); #1;
        enq_valid = 1'b0;
        check("t2_hold_count", count, 3);

        // 3: drain through the SRAM
        deq_ready = 1'b1;
        @(negedge clock);
        check("t3_first_deq", deq_valid, 1);
        @(negedge clock);
        check("t3_rd_en", sram_en, 1);
        check("t3_rd_wmode", sram_wmode, 0);
        check("t3_rd_addr", sram_addr, 0);
        check("t3_rd_deq_valid", deq_valid, 0);
        @(negedge clock);
        check("t3_cap_deq_valid", deq_valid, 0);
        check("t3_cap_sram_en", sram_en, 0);
        check("t3_cap_count", count, 2);
        @(negedge clock);
        check("t3_second_deq", deq_valid, 1);
        wait_drain();

        // 4: wrap under random backpressure
        stim_done = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) enq(72'h100 + 72'(i));
                stim_done = 1;
            end
            begin
                for (int i = 0; i < 400 && !stim_done; i++) begin
                    @(posedge clock); #1;
                    deq_ready = 1'($urandom_range(0, 1));
                end
                deq_ready = 1'b1;
            end
        join
        wait_drain();

        // 5: flush with a read in flight
        deq_ready = 1'b0;
        enq(72'h11);
        enq(72'h22);
        deq_ready = 1'b1;
        @(posedge clock); #1;
        deq_ready = 1'b0;
        @(posedge clock); #1;
        flush = 1'b1;
        @(negedge clock);
        check("t5_inflight_count", count, 1);
        @(posedge clock); #1;
        flush = 1'b0;
        @(negedge clock);
        check("t5_post_count", count, 0);
        check("t5_post_deq_valid", deq_valid, 0);
        @(posedge clock); #1;
        deq_ready = 1'b1;
        enq(72'h3C);
        check("t5_bypass_en", last_en, 0);
        wait_drain();

        // 6: async reset mid-fill
        deq_ready = 1'b0;
        enq(72'hAA);
        enq(72'hBB);
        enq_valid = 1'b1; enq_bits = 72'hCC;
        #1;
        check("t6_pre_sram_en", sram_en, 1);
        reset = 1'b1;
        #1;
        check("t6_rst_sram_en", sram_en, 0);
        check("t6_rst_deq_valid", deq_valid, 0);
        enq_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("t6_count", count, 0);
        check("t6_deq_valid", deq_valid, 0);
        check("t6_enq_ready", enq_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
